// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/data memory arbiter.
//   state_t    : sequencer states (IDLE -> WAIT -> RESP)
//   owner_t    : which port holds the current grant
//   CONFLICT_W : width of the saturating conflict counter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_t;

   localparam int CONFLICT_W = 16;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears count
//   inc     : add one unless already all-ones
//   clear   : synchronous clear, wins over inc
//   count   : current value, sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for a single-ported memory shared by instruction fetch
// and the data-memory stage. One access at a time: issue in IDLE, wait out
// the fixed read latency, pulse the owner's ready in RESP.
//   clock, reset_n        : clock, asynchronous active-low reset
//   if_req/if_addr        : fetch request (held until if_ready)
//   if_rdata/if_ready     : fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request (held until dm_ready)
//   dm_rdata/dm_ready     : load data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory-side interface
//   stall                 : pipeline stall while any request is outstanding
//   conflict_cnt          : saturating count of contended IDLE cycles
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_AW     = 10,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  if_req,
   input  logic [31:0]           if_addr,
   output logic [31:0]           if_rdata,
   output logic                  if_ready,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [31:0]           dm_addr,
   input  logic [31:0]           dm_wdata,
   output logic [31:0]           dm_rdata,
   output logic                  dm_ready,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic                  stall,
   output logic [CONFLICT_W-1:0] conflict_cnt
);

   localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);
   localparam logic [2:0] STARVE_CAP = 3'(STARVE_MAX);

   state_t      state, state_nx;
   owner_t      owner, owner_nx;
   logic        owner_we, owner_we_nx;
   logic [2:0]  lat_cnt, lat_nx;
   logic [2:0]  starve_cnt, starve_nx;
   logic [31:0] if_rdata_nx, dm_rdata_nx;
   logic        if_win;
   logic        conflict;

   // Byte-offset and high address bits are deliberately dropped.
   logic addr_unused;
   assign addr_unused = ^{if_addr[31:MEM_AW+2], if_addr[1:0],
                          dm_addr[31:MEM_AW+2], dm_addr[1:0]};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         owner      <= OWN_IF;
         owner_we   <= 1'b0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         state      <= state_nx;
         owner      <= owner_nx;
         owner_we   <= owner_we_nx;
         lat_cnt    <= lat_nx;
         starve_cnt <= starve_nx;
         if_rdata   <= if_rdata_nx;
         dm_rdata   <= dm_rdata_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      owner_nx    = owner;
      owner_we_nx = owner_we;
      lat_nx      = lat_cnt;
      starve_nx   = starve_cnt;
      if_rdata_nx = if_rdata;
      dm_rdata_nx = dm_rdata;
      if_win      = 1'b0;
      conflict    = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if_ready    = 1'b0;
      dm_ready    = 1'b0;

      unique case (state)
         IDLE: begin
            // Gated by reset_n so nothing is issued while reset is held,
            // even though the state register already reads IDLE.
            if (reset_n && (if_req || dm_req)) begin
               conflict = if_req & dm_req;
               if_win   = if_req & (~dm_req | (starve_cnt == STARVE_CAP));
               mem_en   = 1'b1;
               lat_nx   = LAT_LOAD;
               state_nx = WAIT;
               if (if_win) begin
                  mem_addr    = if_addr[MEM_AW+1:2];
                  owner_nx    = OWN_IF;
                  owner_we_nx = 1'b0;
                  starve_nx   = '0;
               end else begin
                  mem_we      = dm_we;
                  mem_addr    = dm_addr[MEM_AW+1:2];
                  mem_wdata   = dm_wdata;
                  owner_nx    = OWN_DM;
                  owner_we_nx = dm_we;
                  if (if_req) begin
                     starve_nx = starve_cnt + 3'd1;
                  end
               end
            end
         end
         WAIT: begin
            lat_nx = lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) begin
               if (owner == OWN_IF) begin
                  if_rdata_nx = mem_rdata;
               end else if (!owner_we) begin
                  dm_rdata_nx = mem_rdata;
               end
               state_nx = RESP;
            end
         end
         RESP: begin
            if_ready = (owner == OWN_IF);
            dm_ready = (owner == OWN_DM);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

   sat_counter #(
      .W(CONFLICT_W)
   ) u_conflict (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (conflict),
      .clear   (1'b0),
      .count   (conflict_cnt)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic        clock;
   logic        reset_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_en;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall;
   logic [15:0] conflict_cnt;

   logic        sat_inc;
   logic        sat_clr;
   logic [2:0]  sat_count;

   int n_tot;
   int n_bad;

   mem_port_arbiter #(
      .MEM_AW     (10),
      .MEM_LAT    (LAT),
      .STARVE_MAX (SMAX)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_rdata     (if_rdata),
      .if_ready     (if_ready),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata),
      .dm_ready     (dm_ready),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .stall        (stall),
      .conflict_cnt (conflict_cnt)
   );

   // Narrow instance so saturation is reachable in a few cycles.
   sat_counter #(
      .W(3)
   ) u_sat (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (sat_inc),
      .clear   (sat_clr),
      .count   (sat_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] pat(input int i);
      if (i == 2) return 32'h00412820;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   function automatic logic [31:0] wa(input logic [31:0] a);
      return (a >> 2) & 32'h3FF;
   endfunction

   // Memory behind the DUT: synchronous read, data visible LAT cycles
   // after the mem_en cycle, garbage otherwise.
   logic [31:0] mem [1024];
   logic        init_pulse;
   logic        rd_v0, rd_v1;
   logic [31:0] rd_d0, rd_d1;

   always @(posedge clock) begin
      if (init_pulse) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      rd_v0 <= mem_en && !mem_we;
      rd_d0 <= mem[mem_addr];
      rd_v1 <= rd_v0;
      rd_d1 <= rd_d0;
   end
   assign mem_rdata = rd_v1 ? rd_d1 : 32'hDEADBEEF;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n  = 1'b0;
      if_req   = 1'b0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      if_addr  = '0;
      dm_addr  = '0;
      dm_wdata = '0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dd;
      logic        en;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        st;
      int          own;  // 0 none, 1 fetch, 2 data
   } vec_t;

   vec_t tbl [7];

   // reference-model state
   int          free_at, in_issue, in_own, m_starve, m_conf;
   logic        in_valid, in_we, pv_if, pv_dm, ifw;
   logic        e_ifr, e_dmr, e_en, e_we;
   logic [31:0] in_data, m_ifd, m_dmd, e_addr;
   logic [31:0] ref_mem [1024];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_tot = 0; n_bad = 0;
      reset_n = 1'b0; init_pulse = 1'b1;
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
      sat_inc = 0; sat_clr = 0;

      tbl[0] = '{0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,   32'h0,        0, 0};
      tbl[1] = '{1, 32'h8,        0, 0, 32'h0,        32'h0,        1, 0, 32'h2,   32'h0,        1, 1};
      tbl[2] = '{1, 32'hFFFFF00F, 0, 0, 32'h0,        32'h0,        1, 0, 32'h3,   32'h0,        1, 1};
      tbl[3] = '{0, 32'h0,        1, 0, 32'h00000FFC, 32'h0,        1, 0, 32'h3FF, 32'h0,        1, 2};
      tbl[4] = '{0, 32'h0,        1, 1, 32'h12345678, 32'hA5A55A5A, 1, 1, 32'h19E, 32'hA5A55A5A, 1, 2};
      tbl[5] = '{1, 32'h10,       1, 1, 32'h20,       32'h11,       1, 1, 32'h8,   32'h11,       1, 2};
      tbl[6] = '{1, 32'h4,        1, 0, 32'h3,        32'h0,        1, 0, 32'h0,   32'h0,        1, 2};

      do_reset();
      init_pulse = 1'b0;
      #1;
      chk("rst_if_ready", 32'(if_ready), 0);
      chk("rst_dm_ready", 32'(dm_ready), 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_conflict", 32'(conflict_cnt), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_stall", 32'(stall), 0);

      // single fetch
      @(negedge clock); if_req = 1; if_addr = 32'h8; #1;
      chk("fetch_en0", 32'(mem_en), 1);
      chk("fetch_addr0", 32'(mem_addr), 2);
      chk("fetch_we0", 32'(mem_we), 0);
      chk("fetch_stall0", 32'(stall), 1);
      for (int k = 1; k < 3; k++) begin
         @(negedge clock); #1;
         chk("fetch_stall_wait", 32'(stall), 1);
         chk("fetch_en_wait", 32'(mem_en), 0);
         chk("fetch_rdy_wait", 32'(if_ready), 0);
      end
      @(negedge clock); #1;
      chk("fetch_ready3", 32'(if_ready), 1);
      chk("fetch_rdata3", if_rdata, 32'h00412820);
      chk("fetch_stall3", 32'(stall), 0);
      @(negedge clock); if_req = 0; #1;
      chk("fetch_ready4", 32'(if_ready), 0);
      chk("fetch_rdata_held", if_rdata, 32'h00412820);

      // reset during WAIT, then re-issue of held fetch
      @(negedge clock); if_req = 1; if_addr = 32'h8; #1;
      chk("rstmid_en0", 32'(mem_en), 1);
      @(negedge clock); #1;
      reset_n = 0; #1;
      chk("rstmid_en", 32'(mem_en), 0);
      chk("rstmid_if_rdata", if_rdata, 0);
      chk("rstmid_if_ready", 32'(if_ready), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock); #1;
         chk("rstmid_no_ready", 32'(if_ready), 0);
         chk("rstmid_no_en", 32'(mem_en), 0);
      end
      @(negedge clock); reset_n = 1; #1;
      chk("rstmid_reissue_en", 32'(mem_en), 1);
      chk("rstmid_reissue_addr", 32'(mem_addr), 2);
      @(negedge clock); @(negedge clock);
      @(negedge clock); #1;
      chk("rstmid_ready", 32'(if_ready), 1);
      chk("rstmid_rdata", if_rdata, 32'h00412820);
      @(negedge clock); if_req = 0;

      // store then load
      @(negedge clock); dm_req = 1; dm_we = 1; dm_addr = 32'h8; dm_wdata = 32'hFFFFFFF0; #1;
      chk("sw_en", 32'(mem_en), 1);
      chk("sw_we", 32'(mem_we), 1);
      chk("sw_addr", 32'(mem_addr), 2);
      chk("sw_wdata", mem_wdata, 32'hFFFFFFF0);
      @(negedge clock); @(negedge clock);
      @(negedge clock); #1;
      chk("sw_ready", 32'(dm_ready), 1);
      chk("sw_rdata_unchanged", dm_rdata, 0);
      @(negedge clock); dm_we = 0; #1;
      chk("lw_en", 32'(mem_en), 1);
      chk("lw_we", 32'(mem_we), 0);
      @(negedge clock); @(negedge clock);
      @(negedge clock); #1;
      chk("lw_ready", 32'(dm_ready), 1);
      chk("lw_rdata", dm_rdata, 32'hFFFFFFF0);
      @(negedge clock); dm_req = 0;

      // simultaneous requests
      do_reset();
      @(negedge clock); if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h14; #1;
      chk("sim_en0", 32'(mem_en), 1);
      chk("sim_addr0", 32'(mem_addr), 5);
      @(negedge clock); #1;
      chk("sim_conflict1", 32'(conflict_cnt), 1);
      @(negedge clock);
      @(negedge clock); #1;
      chk("sim_dm_ready", 32'(dm_ready), 1);
      chk("sim_if_notready", 32'(if_ready), 0);
      chk("sim_stall_if", 32'(stall), 1);
      @(negedge clock); dm_req = 0; #1;
      chk("sim_if_en", 32'(mem_en), 1);
      chk("sim_if_addr", 32'(mem_addr), 4);
      @(negedge clock); @(negedge clock);
      @(negedge clock); #1;
      chk("sim_if_ready", 32'(if_ready), 1);
      @(negedge clock); if_req = 0; #1;
      chk("sim_conflict_end", 32'(conflict_cnt), 1);

      // starvation guard
      do_reset();
      for (int g = 0; g < 6; g++) begin
         @(negedge clock);
         if_req = 1; dm_req = 1; dm_we = 0;
         dm_addr = 32'h100 + 32'((g < 4 ? g : 4) * 4);
         if_addr = (g == 5) ? 32'h44 : 32'h40;
         #1;
         chk("starve_en", 32'(mem_en), 1);
         if (g == 4) chk("starve_if_grant", 32'(mem_addr), 32'h10);
         else        chk("starve_dm_grant", 32'(mem_addr), 32'h40 + 32'((g < 4 ? g : 4)));
         repeat (3) @(negedge clock);
      end
      if_req = 0; dm_req = 0;
      repeat (4) @(negedge clock);

      // single-cycle issue table from IDLE
      do_reset();
      for (int v = 0; v < 7; v++) begin
         @(negedge clock);
         if_req = tbl[v].ir; if_addr = tbl[v].ia;
         dm_req = tbl[v].dr; dm_we = tbl[v].dw; dm_addr = tbl[v].da; dm_wdata = tbl[v].dd;
         #1;
         chk($sformatf("tbl%0d_en", v), 32'(mem_en), 32'(tbl[v].en));
         chk($sformatf("tbl%0d_stall", v), 32'(stall), 32'(tbl[v].st));
         if (tbl[v].en) begin
            chk($sformatf("tbl%0d_we", v), 32'(mem_we), 32'(tbl[v].we));
            chk($sformatf("tbl%0d_addr", v), 32'(mem_addr), tbl[v].addr);
         end
         if (tbl[v].we) chk($sformatf("tbl%0d_wdata", v), mem_wdata, tbl[v].wd);
         @(negedge clock); if_req = 0; dm_req = 0;
         @(negedge clock);
         @(negedge clock); #1;
         chk($sformatf("tbl%0d_if_ready", v), 32'(if_ready), 32'(tbl[v].own == 1));
         chk($sformatf("tbl%0d_dm_ready", v), 32'(dm_ready), 32'(tbl[v].own == 2));
      end
      chk("tbl_conflict", 32'(conflict_cnt), 2);

      // saturating counter on a narrow instance
      @(negedge clock); sat_inc = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock); #1;
         chk("sat_count", 32'(sat_count), (k + 1 < 7) ? k + 1 : 7);
      end
      sat_inc = 0; sat_clr = 1;
      @(negedge clock); #1;
      chk("sat_clear", 32'(sat_count), 0);
      sat_clr = 0;

      // randomized traffic against a transaction-level model
      @(negedge clock); init_pulse = 1;
      @(posedge clock); #1 init_pulse = 0;
      do_reset();
      for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
      free_at = 0; in_valid = 0; in_issue = 0; in_own = 0; in_we = 0; in_data = 0;
      m_starve = 0; m_conf = 0; m_ifd = 0; m_dmd = 0; pv_if = 0; pv_dm = 0;
      for (int c = 0; c < 700; c++) begin
         @(negedge clock);
         if (!if_req) begin
            if ($urandom_range(0, 2) == 0) begin
               if_req = 1;
               if_addr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            end
         end else if (pv_if) begin
            if ($urandom_range(0, 1) == 1) if_req = 0;
            else if_addr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 7)) << 2);
         end else if ($urandom_range(0, 40) == 0) begin
            if_req = 0;
         end
         if (!dm_req || pv_dm) begin
            if (!dm_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1)) begin
               dm_req = 1;
               dm_we = 1'($urandom_range(0, 1));
               dm_addr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
               dm_wdata = $urandom;
            end else begin
               dm_req = 0;
            end
         end else if ($urandom_range(0, 40) == 0) begin
            dm_req = 0;
         end
         #1;
         e_ifr = 0; e_dmr = 0;
         if (in_valid && c == in_issue + LAT + 1) begin
            if (in_own == 0) begin
               e_ifr = 1; m_ifd = in_data;
            end else begin
               e_dmr = 1;
               if (!in_we) m_dmd = in_data;
            end
            in_valid = 0;
         end
         e_en = 0; e_we = 0; e_addr = 0; ifw = 0;
         if (c >= free_at && (if_req || dm_req)) begin
            ifw = if_req && (!dm_req || m_starve == SMAX);
            e_en = 1;
            e_we = !ifw && dm_we;
            e_addr = ifw ? wa(if_addr) : wa(dm_addr);
         end
         chk("rnd_mem_en", 32'(mem_en), 32'(e_en));
         if (e_en) begin
            chk("rnd_mem_we", 32'(mem_we), 32'(e_we));
            chk("rnd_mem_addr", 32'(mem_addr), e_addr);
         end
         if (e_we) chk("rnd_mem_wdata", mem_wdata, dm_wdata);
         chk("rnd_if_ready", 32'(if_ready), 32'(e_ifr));
         chk("rnd_dm_ready", 32'(dm_ready), 32'(e_dmr));
         chk("rnd_if_rdata", if_rdata, m_ifd);
         chk("rnd_dm_rdata", dm_rdata, m_dmd);
         chk("rnd_stall", 32'(stall), 32'((if_req && !e_ifr) || (dm_req && !e_dmr)));
         chk("rnd_conflict", 32'(conflict_cnt), 32'(m_conf));
         if (c >= free_at && if_req && dm_req && m_conf < 32'hFFFF) m_conf++;
         if (e_en) begin
            in_valid = 1; in_own = ifw ? 0 : 1; in_we = e_we; in_issue = c;
            in_data = ref_mem[e_addr[9:0]];
            if (e_we) ref_mem[e_addr[9:0]] = dm_wdata;
            free_at = c + LAT + 2;
            if (ifw) m_starve = 0;
            else if (if_req) m_starve++;
         end
         pv_if = e_ifr; pv_dm = e_dmr;
      end
      if_req = 0; dm_req = 0;
      repeat (5) @(negedge clock);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single-ported unified memory shared by the pipeline's instruction-fetch (IF) port and data-memory (MEM stage) port. It accepts one request per port, grants the memory to one requester at a time, waits out a fixed memory latency, and returns read data with a one-cycle ready pulse. It also produces a global pipeline stall and a saturating conflict counter. It sits between the pipeline latches and the shared instruction/data RAM.

## Interface
- MEM_AW, 10: memory word-address width (1024 words).
- MEM_LAT, 2: synchronous memory read latency in cycles, legal range 1..7.
- STARVE_MAX, 4: number of consecutive data grants allowed while IF waits.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid while if_ready=1, held otherwise.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held with dm_we, dm_addr, dm_wdata until dm_ready.
- dm_we  in  1  1=store (SW), 0=load (LW).
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; unchanged by stores.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  MEM_AW  word address = granted byte address [MEM_AW+1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  valid MEM_LAT cycles after the mem_en cycle.
- stall  out  1  (if_req & ~if_ready) | (dm_req & ~dm_ready); combinational.
- conflict_cnt  out  16  cycles in IDLE with both requests pending; saturates at 0xFFFF.

## Operation
- FSM states:
  - IDLE: if any request is pending, issue it combinationally (mem_en=1; mem_we, mem_addr, mem_wdata taken from the winner), latch the grant owner, load lat_cnt=MEM_LAT, and go to WAIT. With no request, stay in IDLE.
  - WAIT: decrement lat_cnt each cycle. When lat_cnt==1, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
  - RESP: assert the owner's ready for one cycle, issue nothing, and go to IDLE.
- Priority rule: the data port wins by default. If starve_cnt==STARVE_MAX and if_req=1, IF wins.
- starve_cnt (3 bits):
  - increments when the data port is granted while if_req=1;
  - clears on any IF grant;
  - otherwise holds.
- Address bits [1:0] and bits above MEM_AW+1 are ignored. There is no misalignment fault.
- If a requester drops its request mid-access, the access still completes and ready still pulses. The requester ignores the pulse. Memory writes are never cancelled.
- Stores pulse dm_ready exactly as loads do.

## Timing
- Issue in cycle t → mem_rdata is sampled at the end of cycle t+MEM_LAT → ready is high in cycle t+MEM_LAT+1.
- One access occupies MEM_LAT+2 cycles. The earliest next issue is cycle t+MEM_LAT+2.
- A request that rises in IDLE is issued in the same cycle (zero-cycle grant).
- Both requests rising in the same IDLE cycle: data is issued and conflict_cnt increments. IF is issued at the next IDLE.
- Reset, asynchronous and immediate:
  - state=IDLE, lat_cnt=0, starve_cnt=0;
  - if_ready=dm_ready=0, if_rdata=dm_rdata=0, conflict_cnt=0;
  - mem_en=0 while reset_n=0.
- Reset during WAIT or RESP aborts the access and no ready is produced. An already-issued write may have completed in memory.
- stall is combinational: it is 0 in a requester's ready cycle and 1 in every other cycle of a pending request.

## Structure
- Package mem_arb_pkg holds:
  - the state enum {IDLE, WAIT, RESP};
  - the owner enum {OWN_IF, OWN_DM};
  - constant CONFLICT_W=16.
- One sub-module, sat_counter (parameterised width, inc, clear), instantiated for conflict_cnt. Its output saturates rather than wrapping.
- The latency counter and starvation counter stay inline.

## Test plan
All scenarios use MEM_LAT=2 and STARVE_MAX=4.
- Single fetch: if_req=1, if_addr=0x8, memory word 2 = 0x00412820 → mem_en=1 and mem_addr=2 in cycle 0; if_ready=1 and if_rdata=0x00412820 in cycle 3; stall=1 in cycles 0–2.
- Store then load: SW of 0xFFFFFFF0 to address 0x8, then LW from 0x8 → mem_we=1 in the first issue cycle; dm_ready in cycle 3; load issued in cycle 4, dm_rdata=0xFFFFFFF0 in cycle 7.
- Simultaneous requests: if_req and dm_req both rise in cycle 0 → data is issued in cycle 0 and IF in cycle 4; conflict_cnt=1.
- Starvation guard: dm_req held continuously with new addresses and if_req held → four data grants, the fifth grant goes to IF, then starve_cnt=0.
- Reset mid-access: reset_n low during WAIT → all outputs go to 0 immediately; no ready pulse; after release, the held if_req is re-issued in the first IDLE cycle.
- Saturation: force 0x10000 conflict cycles → conflict_cnt stays at 0xFFFF.
